pe_out_serializer: RTL and testbench
====================================

Name: pe_out_serializer

Overview:
- Output-side counterpart of the PE array's input distributor.
- The input side fans one overlay stream out to PE_NUM lanes. This block does the reverse: it captures the PE_NUM parallel PE result words on a load strobe and serializes them onto the single overlay output stream, one word per accepted beat, PE0 first.
- It replaces the truncating single-word output register with a valid/ready streaming port.

Parameters:
- PE_NUM, default `PE_NUM (8), number of PE lanes captured per load.
- DATA_WIDTH, default `DATA_WIDTH (16); each word is 2*DATA_WIDTH bits (complex re/im pair).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- load  in  1  capture strobe for the parallel PE outputs.
- p_in_v  in  PE_NUM  per-lane valid at capture; bit j belongs to PE j.
- p_in  in  PE_NUM*2*DATA_WIDTH  lane j occupies bits [(j+1)*2*DATA_WIDTH-1 : j*2*DATA_WIDTH].
- s_out_ready  in  1  downstream accepts the current beat.
- s_out_v  out  1  serial word valid.
- s_out  out  2*DATA_WIDTH  serial word.
- s_out_last  out  1  high with the final word of a capture.
- busy  out  1  a capture is being drained.
- overflow  out  1  sticky; a load was dropped.

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset rst, sampled on posedge clk only.
- Reset values: s_out_v=0, s_out=0, s_out_last=0, busy=0, overflow=0, lane index=0, FSM=IDLE. Capture buffer contents are don't-care.
- FSM states: IDLE, DRAIN.
- IDLE, load=1:
  - Register p_in into the buffer and p_in_v into the mask.
  - Set lane index to the first lane to emit; busy=1; go to DRAIN.
  - s_out_v rises the cycle after load (latency 1), carrying that lane's word.
- DRAIN, handshake:
  - A beat transfers when s_out_v && s_out_ready.
  - While s_out_v=1 and s_out_ready=0, s_out, s_out_v and s_out_last hold stable.
  - On transfer, the next lane's word is registered onto s_out in the same edge, giving full throughput of 1 word/cycle with ready held high.
- Ordering: ascending lane index 0..PE_NUM-1.
- Last beat: s_out_last=1 only on the final emitted word. When that beat transfers, go to IDLE; s_out_v=0, busy=0, s_out_last=0 next cycle. s_out is zeroed whenever s_out_v=0.
- load in DRAIN:
  - If load is asserted in DRAIN on any cycle other than the final-beat transfer, it is ignored, the buffer is unchanged, and overflow is set.
  - Back-to-back case: load coincident with the final-beat transfer is accepted. The FSM stays in DRAIN, the new word 0 appears next cycle with no bubble, and overflow is not set.
- overflow clears only on rst.
- s_out_ready is ignored while s_out_v=0. There is no combinational path from any input to any output.
- rst mid-drain: remaining words are discarded; outputs take reset values the next cycle.

Optional Feature:
- Macro: PISO_SKIP_INVALID_EN.
- Defined:
  - Lanes whose captured valid bit is 0 are skipped. The index jumps directly to the next set lane in the same cycle, so there are no bubbles.
  - s_out_last marks the highest set lane.
  - load with p_in_v==0 emits nothing: stays IDLE, busy=0, overflow unaffected.
- Undefined:
  - All PE_NUM lanes are emitted regardless of p_in_v; s_out_last is on lane PE_NUM-1.
  - load with p_in_v==0 still emits PE_NUM words. The mask register may be optimized away.

Decomposition:
- Shared include parameters.vh: DATA_WIDTH and PE_NUM. No new package.
- Local: FSM state encodings (IDLE=1'b0, DRAIN=1'b1) and WORD_W = 2*DATA_WIDTH.
- One natural sub-module: piso_lane_sel. It is a combinational next-set-lane finder with inputs mask and current index, and outputs next index and an is_last flag. It is instantiated only when PISO_SKIP_INVALID_EN is defined; otherwise it becomes a simple increment.

Test Plan (PE_NUM=4, DATA_WIDTH=16):
- Basic drain: load, p_in={32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, p_in_v=4'hF, ready=1 -> s_out_v cycles t+1..t+4 with words 1111_0001, 2222_0002, 3333_0003, 4444_0004; s_out_last at t+4; busy low at t+5.
- Backpressure: same data, ready low for 3 cycles after the first beat -> s_out holds 32'h1111_0001 stable; exactly 4 transfers total; no duplicates or drops.
- Overflow and back-to-back: second load at t+2 -> ignored, overflow=1 and sticky. Third load coincident with the last-beat transfer -> 4 new words follow with no idle cycle; overflow not re-triggered by that load.
- Skip (PISO_SKIP_INVALID_EN): p_in_v=4'b1010 -> exactly 2 words (lane1, lane3), s_out_last on lane3. p_in_v=4'b0000 -> no s_out_v, busy stays 0. Without the macro the same stimulus yields 4 words.
- Reset mid-drain: rst at the second beat -> next cycle s_out_v=0, s_out_last=0, busy=0, overflow=0; a following load drains normally from lane 0.

Source files
------------

// File: rtl/pe_out_serializer_pkg.sv
// pe_out_serializer_pkg
//   Shared definitions for the PE output serializer slice: default lane count
//   and word width, the drain FSM state type, and a helper that sizes lane
//   index registers.
//   No ports (package).
package pe_out_serializer_pkg;

  localparam int PE_NUM_DEFAULT     = 8;
  localparam int DATA_WIDTH_DEFAULT = 16;

  // Drain controller states: IDLE waits for a capture, DRAIN streams it out.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Width of a register able to hold a lane number 0..n-1 (at least 1 bit).
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_out_serializer_if.sv
// pe_out_serializer_if
//   Bundles the parallel capture port and the serial valid/ready output
//   stream of pe_out_serializer.
//   Signals:
//     load        capture strobe for the parallel PE outputs
//     p_in_v      per-lane valid at capture (bit j = PE j)
//     p_in        packed PE words, lane j at [(j+1)*W-1 : j*W], W = 2*DATA_WIDTH
//     s_out_ready downstream accepts the current beat
//     s_out_v     serial word valid
//     s_out       serial word
//     s_out_last  final word of a capture
//     busy        a capture is being drained
//     overflow    sticky, a load was dropped
//   Modports: master drives load/p_in/ready, slave is the serializer.
interface pe_out_serializer_if
  import pe_out_serializer_pkg::*;
#(
  parameter int PE_NUM     = PE_NUM_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic                           load;
  logic [PE_NUM-1:0]              p_in_v;
  logic [PE_NUM*2*DATA_WIDTH-1:0] p_in;
  logic                           s_out_ready;
  logic                           s_out_v;
  logic [2*DATA_WIDTH-1:0]        s_out;
  logic                           s_out_last;
  logic                           busy;
  logic                           overflow;

  modport master (
    output load, p_in_v, p_in, s_out_ready,
    input  s_out_v, s_out, s_out_last, busy, overflow
  );

  modport slave (
    input  load, p_in_v, p_in, s_out_ready,
    output s_out_v, s_out, s_out_last, busy, overflow
  );

endinterface

// File: rtl/pe_out_serializer_lane_sel.sv
// piso_lane_sel
//   Combinational next-set-lane finder used when invalid lanes are skipped
//   (only compiled with PISO_SKIP_INVALID_EN defined).
//   Ports:
//     mask_i        captured per-lane valid bits
//     cur_idx_i     lane currently presented
//     from_start_i  1: search from lane 0 inclusive (first lane of a capture)
//                   0: search strictly above cur_idx_i
//     next_idx_o    lowest qualifying set lane
//     found_o       a qualifying set lane exists
//     is_last_o     no set lane exists above next_idx_o
`ifdef PISO_SKIP_INVALID_EN
module piso_lane_sel #(
  parameter int PE_NUM = 8,
  parameter int IDX_W  = 3
) (
  input  logic [PE_NUM-1:0] mask_i,
  input  logic [IDX_W-1:0]  cur_idx_i,
  input  logic              from_start_i,
  output logic [IDX_W-1:0]  next_idx_o,
  output logic              found_o,
  output logic              is_last_o
);

  // The first qualifying lane becomes the answer; any further set lane seen
  // afterwards means the answer is not the final one.
  always_comb begin
    next_idx_o = '0;
    found_o    = 1'b0;
    is_last_o  = 1'b1;
    for (int j = 0; j < PE_NUM; j++) begin
      if (mask_i[j] && (from_start_i || (IDX_W'(j) > cur_idx_i))) begin
        if (!found_o) begin
          next_idx_o = IDX_W'(j);
          found_o    = 1'b1;
        end else begin
          is_last_o = 1'b0;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/pe_out_serializer.sv
// pe_out_serializer
//   Captures PE_NUM parallel PE result words on a load strobe and streams them
//   out one word per accepted beat, lane 0 first, on a valid/ready port.
//   All outputs are registered; a load arriving with the final-beat transfer
//   is accepted back-to-back, any other load during a drain is dropped and
//   flagged on the sticky overflow output.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  pe_out_serializer_if.slave (load/p_in_v/p_in/s_out_ready in,
//          s_out_v/s_out/s_out_last/busy/overflow out)
//   Configuration macro:
//     PISO_SKIP_INVALID_EN  defined: lanes with a cleared captured valid bit are
//                           skipped and a load with no valid lanes emits nothing.
//                           undefined: every lane is emitted.
module pe_out_serializer
  import pe_out_serializer_pkg::*;
#(
  parameter int PE_NUM     = PE_NUM_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  pe_out_serializer_if.slave bus
);

  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int IDX_W  = idxWidth(PE_NUM);

  state_e                   state_q, state_d;
  logic [PE_NUM*WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORD_W-1:0]        out_q, out_d;
  logic                     out_v_q, out_v_d;
  logic                     last_q, last_d;
  logic                     ovf_q, ovf_d;

  logic                     xfer;
  logic                     capture;
  logic [IDX_W-1:0]         first_idx;
  logic                     first_found;
  logic                     first_last;
  logic [IDX_W-1:0]         step_idx;
  logic                     step_last;

  assign xfer = out_v_q && bus.s_out_ready;

`ifdef PISO_SKIP_INVALID_EN
  logic [PE_NUM-1:0] mask_q;
  logic              step_found_unused;

  // First lane to emit is searched directly on the incoming valid bits so it
  // can be presented one cycle after load.
  piso_lane_sel #(.PE_NUM(PE_NUM), .IDX_W(IDX_W)) u_first_sel (
    .mask_i       (bus.p_in_v),
    .cur_idx_i    ('0),
    .from_start_i (1'b1),
    .next_idx_o   (first_idx),
    .found_o      (first_found),
    .is_last_o    (first_last)
  );

  // Subsequent lanes are searched on the captured mask. A step is only taken
  // while the presented word is not the last, so a next lane always exists.
  piso_lane_sel #(.PE_NUM(PE_NUM), .IDX_W(IDX_W)) u_step_sel (
    .mask_i       (mask_q),
    .cur_idx_i    (idx_q),
    .from_start_i (1'b0),
    .next_idx_o   (step_idx),
    .found_o      (step_found_unused),
    .is_last_o    (step_last)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      mask_q <= bus.p_in_v;
    end
  end
`else
  logic unused_lane_valid;

  // Every lane is emitted, so the valid bits play no part.
  assign unused_lane_valid = ^bus.p_in_v;
  assign first_idx         = '0;
  assign first_found       = 1'b1;
  assign first_last        = (PE_NUM == 1);
  assign step_idx          = idx_q + 1'b1;
  assign step_last         = (step_idx == IDX_W'(PE_NUM - 1));
`endif

  // Next-state logic. The word that will be on s_out next cycle is selected
  // here and registered, so outputs never depend combinationally on inputs.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          capture = 1'b1;
        end
      end
      DRAIN: begin
        if (xfer && last_q) begin
          if (bus.load) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            out_d   = '0;
            out_v_d = 1'b0;
            last_d  = 1'b0;
          end
        end else begin
          if (xfer) begin
            idx_d  = step_idx;
            out_d  = buf_q[step_idx*WORD_W +: WORD_W];
            last_d = step_last;
          end
          if (bus.load) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Capture path is shared by the IDLE load and the back-to-back load.
    if (capture) begin
      buf_d = bus.p_in;
      if (first_found) begin
        state_d = DRAIN;
        idx_d   = first_idx;
        out_d   = bus.p_in[first_idx*WORD_W +: WORD_W];
        out_v_d = 1'b1;
        last_d  = first_last;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        out_d   = '0;
        out_v_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture buffer has no reset; its contents only matter while draining.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.s_out_v    = out_v_q;
  assign bus.s_out      = out_q;
  assign bus.s_out_last = last_q;
  assign bus.busy       = (state_q == DRAIN);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_pe_out_serializer.sv
// tb_pe_out_serializer
//   Self-checking bench for pe_out_serializer with PE_NUM=4, DATA_WIDTH=16.
//   A queue-based reference model predicts the stream every cycle; a table of
//   hand-written vectors pins down the basic, backpressure, overflow,
//   back-to-back and reset sequences, followed by skip-lane sequences and a
//   randomized run.
module tb_pe_out_serializer;

  localparam int PE_NUM     = 4;
  localparam int DATA_WIDTH = 16;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;
  int   cycleNo;

  pe_out_serializer_if #(.PE_NUM(PE_NUM), .DATA_WIDTH(DATA_WIDTH)) bus ();

  pe_out_serializer #(.PE_NUM(PE_NUM), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending beats of the current capture plus the sticky flag.
  typedef struct {
    logic [31:0] w;
    logic        l;
  } beat_t;

  beat_t mq[$];
  logic  mOvf;

  typedef struct {
    logic        rst;
    logic        load;
    logic        alt;
    logic        rdy;
    logic        expV;
    logic [31:0] expW;
    logic        expL;
    logic        expB;
    logic        expO;
  } vec_t;

  localparam logic [127:0] DATA_A = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
  localparam logic [127:0] DATA_B = {32'hD3D3_0404, 32'hC2C2_0303, 32'hB1B1_0202, 32'hA0A0_0101};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNo, act, exp);
    end
  endtask

  function automatic logic laneSelected(input logic [3:0] v, input int j);
`ifdef PISO_SKIP_INVALID_EN
    return v[j];
`else
    return 1'b1;
`endif
  endfunction

  // Advance the model across one clock edge given the inputs for that edge.
  task automatic modelStep(input logic r, input logic ld, input logic [3:0] v,
                           input logic [127:0] d, input logic rdy);
    logic  wasBusy;
    logic  fin;
    int    lastJ;
    beat_t b;
    if (r) begin
      mq.delete();
      mOvf = 1'b0;
    end else begin
      wasBusy = (mq.size() > 0);
      fin     = 1'b0;
      if (wasBusy && rdy) begin
        fin = (mq.size() == 1);
        void'(mq.pop_front());
      end
      if (ld) begin
        if (!wasBusy || fin) begin
          lastJ = -1;
          for (int j = 0; j < PE_NUM; j++) begin
            if (laneSelected(v, j)) lastJ = j;
          end
          for (int j = 0; j < PE_NUM; j++) begin
            if (laneSelected(v, j)) begin
              b.w = d[j*32 +: 32];
              b.l = (j == lastJ);
              mq.push_back(b);
            end
          end
        end else begin
          mOvf = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic expV;
    expV = (mq.size() > 0);
    cmp("s_out_v", 32'(bus.s_out_v), 32'(expV));
    cmp("s_out", bus.s_out, expV ? mq[0].w : 32'h0);
    cmp("s_out_last", 32'(bus.s_out_last), expV ? 32'(mq[0].l) : 32'h0);
    cmp("busy", 32'(bus.busy), 32'(expV));
    cmp("overflow", 32'(bus.overflow), 32'(mOvf));
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] v,
                               input logic [127:0] d, input logic rdy);
    rst             = r;
    bus.load        = ld;
    bus.p_in_v      = v;
    bus.p_in        = d;
    bus.s_out_ready = rdy;
    modelStep(r, ld, v, d, rdy);
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput();
  endtask

  function automatic vec_t mkVec(input logic r, input logic ld, input logic alt, input logic rdy,
                                 input logic ev, input logic [31:0] ew, input logic el,
                                 input logic eb, input logic eo);
    vec_t t;
    t.rst = r; t.load = ld; t.alt = alt; t.rdy = rdy;
    t.expV = ev; t.expW = ew; t.expL = el; t.expB = eb; t.expO = eo;
    return t;
  endfunction

  vec_t vecs[31];
  int   beats;
  int   nV;

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    cycleNo     = 0;
    rst             = 1'b1;
    bus.load        = 1'b0;
    bus.p_in_v      = '0;
    bus.p_in        = '0;
    bus.s_out_ready = 1'b0;
    mq.delete();
    mOvf = 1'b0;

    // Reset, basic drain
    vecs[0]  = mkVec(1, 0, 0, 1, 0, 32'h0,         0, 0, 0);
    vecs[1]  = mkVec(0, 1, 0, 1, 1, 32'h1111_0001, 0, 1, 0);
    vecs[2]  = mkVec(0, 0, 0, 1, 1, 32'h2222_0002, 0, 1, 0);
    vecs[3]  = mkVec(0, 0, 0, 1, 1, 32'h3333_0003, 0, 1, 0);
    vecs[4]  = mkVec(0, 0, 0, 1, 1, 32'h4444_0004, 1, 1, 0);
    vecs[5]  = mkVec(0, 0, 0, 1, 0, 32'h0,         0, 0, 0);
    // Backpressure after the first beat
    vecs[6]  = mkVec(0, 1, 0, 0, 1, 32'h1111_0001, 0, 1, 0);
    vecs[7]  = mkVec(0, 0, 0, 0, 1, 32'h1111_0001, 0, 1, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 1, 32'h1111_0001, 0, 1, 0);
    vecs[9]  = mkVec(0, 0, 0, 0, 1, 32'h1111_0001, 0, 1, 0);
    vecs[10] = mkVec(0, 0, 0, 1, 1, 32'h2222_0002, 0, 1, 0);
    vecs[11] = mkVec(0, 0, 0, 1, 1, 32'h3333_0003, 0, 1, 0);
    vecs[12] = mkVec(0, 0, 0, 1, 1, 32'h4444_0004, 1, 1, 0);
    vecs[13] = mkVec(0, 0, 0, 1, 0, 32'h0,         0, 0, 0);
    // Dropped load mid-drain, then back-to-back load on the final beat
    vecs[14] = mkVec(0, 1, 0, 1, 1, 32'h1111_0001, 0, 1, 0);
    vecs[15] = mkVec(0, 0, 0, 1, 1, 32'h2222_0002, 0, 1, 0);
    vecs[16] = mkVec(0, 1, 1, 1, 1, 32'h3333_0003, 0, 1, 1);
    vecs[17] = mkVec(0, 0, 0, 1, 1, 32'h4444_0004, 1, 1, 1);
    vecs[18] = mkVec(0, 1, 1, 1, 1, 32'hA0A0_0101, 0, 1, 1);
    vecs[19] = mkVec(0, 0, 0, 1, 1, 32'hB1B1_0202, 0, 1, 1);
    vecs[20] = mkVec(0, 0, 0, 1, 1, 32'hC2C2_0303, 0, 1, 1);
    vecs[21] = mkVec(0, 0, 0, 1, 1, 32'hD3D3_0404, 1, 1, 1);
    vecs[22] = mkVec(0, 0, 0, 1, 0, 32'h0,         0, 0, 1);
    // Reset at the second beat, then a clean drain
    vecs[23] = mkVec(0, 1, 0, 1, 1, 32'h1111_0001, 0, 1, 1);
    vecs[24] = mkVec(0, 0, 0, 1, 1, 32'h2222_0002, 0, 1, 1);
    vecs[25] = mkVec(1, 0, 0, 1, 0, 32'h0,         0, 0, 0);
    vecs[26] = mkVec(0, 1, 0, 1, 1, 32'h1111_0001, 0, 1, 0);
    vecs[27] = mkVec(0, 0, 0, 1, 1, 32'h2222_0002, 0, 1, 0);
    vecs[28] = mkVec(0, 0, 0, 1, 1, 32'h3333_0003, 0, 1, 0);
    vecs[29] = mkVec(0, 0, 0, 1, 1, 32'h4444_0004, 1, 1, 0);
    vecs[30] = mkVec(0, 0, 0, 1, 0, 32'h0,         0, 0, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 31; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].load, 4'hF, vecs[i].alt ? DATA_B : DATA_A, vecs[i].rdy);
      cmp("tbl_v", 32'(bus.s_out_v), 32'(vecs[i].expV));
      cmp("tbl_word", bus.s_out, vecs[i].expW);
      cmp("tbl_last", 32'(bus.s_out_last), 32'(vecs[i].expL));
      cmp("tbl_busy", 32'(bus.busy), 32'(vecs[i].expB));
      cmp("tbl_ovf", 32'(bus.overflow), 32'(vecs[i].expO));
    end

    // Partial valid mask: lanes 1 and 3 only
    $display("[TB] partial valid mask");
    beats = 0;
    applyStimulus(0, 1, 4'b1010, DATA_B, 1);
    if (bus.s_out_v) beats++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 4'b0000, DATA_A, 1);
      if (bus.s_out_v) beats++;
    end
`ifdef PISO_SKIP_INVALID_EN
    nV = 2;
`else
    nV = 4;
`endif
    cmp("skip_beats", 32'(beats), 32'(nV));

    // Empty valid mask
    $display("[TB] empty valid mask");
    applyStimulus(0, 1, 4'b0000, DATA_A, 1);
`ifdef PISO_SKIP_INVALID_EN
    cmp("empty_busy", 32'(bus.busy), 32'h0);
`else
    cmp("empty_busy", 32'(bus.busy), 32'h1);
`endif
    beats = (bus.s_out_v) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 4'b0000, DATA_A, 1);
      if (bus.s_out_v) beats++;
    end
`ifdef PISO_SKIP_INVALID_EN
    nV = 0;
`else
    nV = 4;
`endif
    cmp("empty_beats", 32'(beats), 32'(nV));

    // Randomized traffic against the model
    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic        ld;
      logic [3:0]  v;
      logic [127:0] d;
      logic        rdy;
      r   = ($urandom_range(0, 79) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      v   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      d   = {$urandom, $urandom, $urandom, $urandom};
      rdy = ($urandom_range(0, 9) < 7);
      applyStimulus(r, ld, v, d, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
